// File: rtl/synthesijer_fp64_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synthesijer_fp64_pkg
// Description : Shared FP64 width, counter-width helper and canonical FP64
//               constants for the issue buffer and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package synthesijer_fp64_pkg;

    localparam int FP64_W = 64;

    localparam logic [FP64_W-1:0] FP64_ONE   = 64'h3FF0000000000000;
    localparam logic [FP64_W-1:0] FP64_TWO   = 64'h4000000000000000;
    localparam logic [FP64_W-1:0] FP64_THREE = 64'h4008000000000000;

    // Bits needed to hold any value 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/synthesijer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : synthesijer_sync_fifo
// Description : Register-based synchronous FIFO. Head is presented directly
//               from storage. No overflow/underflow protection: the caller
//               guarantees push never hits a full FIFO and pop never an empty
//               one (push and pop together are legal when non-empty).
// Ports       : clk, rst (sync, active-high)
//               i_push/i_data - write strobe and data
//               i_pop         - read strobe
//               o_head        - oldest entry
//               o_cnt         - occupancy 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module synthesijer_sync_fifo
    import synthesijer_fp64_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic [WIDTH-1:0]          i_data,
    input  logic                      i_pop,
    output logic [WIDTH-1:0]          o_head,
    output logic [cnt_w(DEPTH)-1:0]   o_cnt
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_cnt;

    // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + c_PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + c_CW'(1);
                2'b01:   r_cnt <= r_cnt - c_CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_head = r_mem[r_rd_ptr];
    assign o_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/synthesijer_fp64_issue_buffer.sv
`default_nettype none
// ============================================================================
// Module      : synthesijer_fp64_issue_buffer
// Description : Ready/valid wrapper around a fixed-latency, non-stallable FP64
//               operator. Operands are issued as one-cycle fu_nd pulses and
//               every result is captured in a FIFO. Credits (inflight plus
//               FIFO occupancy) cap outstanding work at DEPTH so no operator
//               result is ever lost. After reset a drain window of
//               FU_LATENCY+1 cycles swallows stale operator results.
// Ports       : clk, reset (sync, active-high)
//               s_a/s_b/s_valid/s_ready   - operand pair input handshake
//               fu_a/fu_b/fu_nd           - registered issue to operator
//               fu_result/fu_valid        - operator result strobe
//               m_result/m_valid/m_ready  - buffered result output handshake
//               count                     - inflight + FIFO occupancy
//               busy                      - work outstanding or draining
//               err (SYNTHESIJER_FP64_CHECK_EN only) - sticky protocol error
// Options     : `define SYNTHESIJER_FP64_CHECK_EN adds the err output and
//               drops unexpected operator results.
// Revision    : 1.0 - initial release
// ============================================================================
module synthesijer_fp64_issue_buffer
    import synthesijer_fp64_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int FU_LATENCY = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [FP64_W-1:0]         s_a,
    input  logic [FP64_W-1:0]         s_b,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [FP64_W-1:0]         fu_a,
    output logic [FP64_W-1:0]         fu_b,
    output logic                      fu_nd,
    input  logic [FP64_W-1:0]         fu_result,
    input  logic                      fu_valid,
    output logic [FP64_W-1:0]         m_result,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      busy
`ifdef SYNTHESIJER_FP64_CHECK_EN
    ,
    output logic                      err
`endif
);

    localparam int c_CW = cnt_w(DEPTH);
    localparam int c_DW = $clog2(FU_LATENCY + 2);
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
    localparam logic [c_DW-1:0] c_DRAIN = c_DW'(FU_LATENCY + 1);

    logic [c_DW-1:0]   r_drain_cnt;
    logic [c_CW-1:0]   r_inflight;
    logic [FP64_W-1:0] r_fu_a;
    logic [FP64_W-1:0] r_fu_b;
    logic              r_fu_nd;

    logic [c_CW-1:0]   w_fifo_cnt;
    logic [c_CW-1:0]   w_total;
    logic [FP64_W-1:0] w_head;
    logic              w_drain;
    logic              w_fire;
    logic              w_pop;
    logic              w_res;
    logic              w_push;

    assign w_drain = (r_drain_cnt != '0);
    assign w_total = r_inflight + w_fifo_cnt;
    // Credit check uses registered state only; a credit freed by a pop is
    // therefore visible one cycle later.
    assign s_ready = !reset && !w_drain && (w_total < c_DEPTH);
    assign w_fire  = s_valid && s_ready;
    assign m_valid = (w_fifo_cnt != '0);
    assign w_pop   = m_valid && m_ready;
    // Results during the drain window may belong to pre-reset operations.
    assign w_res   = fu_valid && !w_drain;

`ifdef SYNTHESIJER_FP64_CHECK_EN
    logic w_bad;
    logic r_err;
    assign w_bad  = w_res && ((r_inflight == '0) || ((w_fifo_cnt == c_DEPTH) && !w_pop));
    assign w_push = w_res && !w_bad;
    assign err    = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_bad) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_push = w_res;
`endif

    // Counter is loaded on reset so the drain window starts the first cycle
    // reset is low; busy/s_ready are gated by reset so nothing shows early.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drain_cnt <= c_DRAIN;
        end else if (w_drain) begin
            r_drain_cnt <= r_drain_cnt - c_DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fu_a     <= '0;
            r_fu_b     <= '0;
            r_fu_nd    <= 1'b0;
            r_inflight <= '0;
        end else begin
            r_fu_nd <= w_fire;
            if (w_fire) begin
                r_fu_a <= s_a;
                r_fu_b <= s_b;
            end
            case ({w_fire, w_push})
                2'b10:   r_inflight <= r_inflight + c_CW'(1);
                2'b01:   r_inflight <= r_inflight - c_CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    synthesijer_sync_fifo #(
        .WIDTH (FP64_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (reset),
        .i_push (w_push),
        .i_data (fu_result),
        .i_pop  (w_pop),
        .o_head (w_head),
        .o_cnt  (w_fifo_cnt)
    );

    assign fu_a     = r_fu_a;
    assign fu_b     = r_fu_b;
    assign fu_nd    = r_fu_nd;
    assign m_result = w_head;
    assign count    = w_total;
    assign busy     = !reset && ((w_total != '0) || w_drain);

endmodule
`default_nettype wire

// File: tb/tb_synthesijer_fp64_issue_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_synthesijer_fp64_issue_buffer
// Description : Scoreboard bench for the FP64 issue buffer with a behavioural
//               16-cycle FP64 adder acting as the operator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_synthesijer_fp64_issue_buffer;
    import synthesijer_fp64_pkg::*;

    localparam int DEPTH      = 8;
    localparam int FU_LATENCY = 16;
    localparam int CW         = cnt_w(DEPTH);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [63:0]       s_a = '0;
    logic [63:0]       s_b = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [63:0]       fu_a;
    logic [63:0]       fu_b;
    logic              fu_nd;
    logic [63:0]       fu_result;
    logic              fu_valid;
    logic [63:0]       m_result;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [CW-1:0]     count;
    logic              busy;
`ifdef SYNTHESIJER_FP64_CHECK_EN
    logic              err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    synthesijer_fp64_issue_buffer #(
        .DEPTH      (DEPTH),
        .FU_LATENCY (FU_LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_a       (s_a),
        .s_b       (s_b),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .fu_a      (fu_a),
        .fu_b      (fu_b),
        .fu_nd     (fu_nd),
        .fu_result (fu_result),
        .fu_valid  (fu_valid),
        .m_result  (m_result),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .count     (count),
        .busy      (busy)
`ifdef SYNTHESIJER_FP64_CHECK_EN
        ,
        .err       (err)
`endif
    );

    function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) + $bitstoreal(b));
    endfunction

    // Values k/16 with k in [-2048, 2047]: sums are exact in FP64.
    function automatic logic [63:0] rnd_fp();
        int k;
        k = int'($urandom_range(0, 4095)) - 2048;
        return $realtobits($itor(k) / 16.0);
    endfunction

    // Behavioural operator: fixed latency, no reset, no stall.
    logic [FU_LATENCY-1:0] pipe_v = '0;
    logic [63:0]           pipe_d [FU_LATENCY] = '{default: '0};
    logic                  inj_valid = 1'b0;
    logic [63:0]           inj_data = '0;

    always @(posedge clk) begin
        pipe_v    <= {pipe_v[FU_LATENCY-2:0], fu_nd};
        pipe_d[0] <= fadd(fu_a, fu_b);
        for (int i = 1; i < FU_LATENCY; i++) begin
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    assign fu_valid  = pipe_v[FU_LATENCY-1] | inj_valid;
    assign fu_result = inj_valid ? inj_data : pipe_d[FU_LATENCY-1];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Input side of the scoreboard: every accepted pair predicts one result.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else if (s_valid && s_ready) begin
            exp_q.push_back(fadd(s_a, s_b));
        end
    end

    // Output side: every pop is compared against the oldest prediction.
    always @(negedge clk) begin
        if (!reset && m_valid && m_ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got %h expected no result", m_result);
            end else begin
                check("sb_result", m_result, exp_q.pop_front());
            end
        end
    end

    // Credit bound must hold on every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            check("count_bound", 64'(count <= CW'(DEPTH)), 64'd1);
        end
    end

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (count == '0 && !m_valid && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({"idle_", nm}, 64'(ok), 64'd1);
    endtask

    // Counts cycles with s_ready low after reset release; optionally injects
    // a stray operator result in the middle of the window.
    task automatic measure_drain(input bit inject, output int zeros, output bit saw_mv, output bit busy_lo);
        zeros   = 0;
        saw_mv  = 1'b0;
        busy_lo = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            saw_mv |= m_valid;
            if (s_ready) break;
            zeros++;
            if (!busy) busy_lo = 1'b1;
            @(posedge clk); #1;
            inj_valid = inject && (zeros == 5);
            inj_data  = 64'h4010_0000_0000_0000;
        end
    endtask

    task automatic issue_n(input int n);
        int  acc;
        bit  fired;
        acc = 0;
        s_valid = 1'b1;
        s_a = rnd_fp();
        s_b = rnd_fp();
        for (int k = 0; k < 100 && acc < n; k++) begin
            @(negedge clk);
            fired = s_valid && s_ready;
            @(posedge clk); #1;
            if (fired) begin
                acc++;
                s_a = rnd_fp();
                s_b = rnd_fp();
                if (acc == n) s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        check("issue_n", 64'(acc), 64'(n));
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int  zeros;
        bit  saw_mv;
        bit  busy_lo;
        int  acc;
        bit  fired;
        int  lat;
        int  p0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fu_nd",    64'(fu_nd),    64'd0);
        check("rst_fu_a",     fu_a,          64'd0);
        check("rst_fu_b",     fu_b,          64'd0);
        check("rst_m_valid",  64'(m_valid),  64'd0);
        check("rst_m_result", m_result,      64'd0);
        check("rst_count",    64'(count),    64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_s_ready",  64'(s_ready),  64'd0);
`ifdef SYNTHESIJER_FP64_CHECK_EN
        check("rst_err",      64'(err),      64'd0);
`endif

        // Drain window with s_valid held high and a stray result injected
        @(posedge clk); #1;
        reset   = 1'b0;
        s_valid = 1'b1;
        s_a     = rnd_fp();
        s_b     = rnd_fp();
        m_ready = 1'b1;
        measure_drain(1'b1, zeros, saw_mv, busy_lo);
        check("drain_len",    64'(zeros),   64'd17);
        check("drain_mvalid", 64'(saw_mv),  64'd0);
        check("drain_busy",   64'(busy_lo), 64'd0);
        @(posedge clk); #1;
        s_valid   = 1'b0;
        inj_valid = 1'b0;
        wait_idle("post_drain");

        // Directed 1.0 + 2.0
        @(posedge clk); #1;
        s_a = FP64_ONE;
        s_b = FP64_TWO;
        s_valid = 1'b1;
        @(negedge clk);
        check("dir_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_a = '0;
        s_b = '0;
        @(negedge clk);
        check("dir_nd_pulse", 64'(fu_nd), 64'd1);
        check("dir_fu_a", fu_a, FP64_ONE);
        check("dir_fu_b", fu_b, FP64_TWO);
        @(negedge clk);
        check("dir_nd_single", 64'(fu_nd), 64'd0);
        check("dir_fu_a_hold", fu_a, FP64_ONE);
        lat = 2;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            lat++;
            if (m_valid) break;
        end
        check("dir_latency", 64'(lat), 64'd18);
        check("dir_result", m_result, FP64_THREE);
        wait_idle("dir");
        check("dir_count0", 64'(count), 64'd0);

        // Backpressure: 10 offered, 8 credits
        @(posedge clk); #1;
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_a = rnd_fp();
        s_b = rnd_fp();
        acc = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            fired = s_valid && s_ready;
            @(posedge clk); #1;
            if (fired) begin
                acc++;
                s_a = rnd_fp();
                s_b = rnd_fp();
                if (acc == 10) s_valid = 1'b0;
            end
        end
        check("bp_accepted", 64'(acc), 64'd8);
        @(negedge clk);
        check("bp_s_ready_low", 64'(s_ready), 64'd0);
        check("bp_count_full",  64'(count),   64'd8);
        check("bp_m_valid",     64'(m_valid), 64'd1);
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(negedge clk);
        check("bp_pop_same_cycle", 64'(s_ready), 64'd0);
        @(posedge clk); #1;
        m_ready = 1'b0;
        @(negedge clk);
        check("bp_credit_back", 64'(s_ready), 64'd1);
        check("bp_count_7",     64'(count),   64'd7);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        check("bp_ninth_count", 64'(count),   64'd8);
        check("bp_ninth_full",  64'(s_ready), 64'd0);
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_idle("bp");

        // 100 sequential integer pairs, consumer always ready
        @(posedge clk); #1;
        p0 = n_pops;
        acc = 0;
        s_valid = 1'b1;
        s_a = $realtobits(0.0);
        s_b = $realtobits(1.0);
        for (int k = 0; k < 3000 && acc < 100; k++) begin
            @(negedge clk);
            fired = s_valid && s_ready;
            @(posedge clk); #1;
            if (fired) begin
                acc++;
                s_a = $realtobits($itor(acc));
                s_b = $realtobits($itor(acc + 1));
                if (acc == 100) s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        check("stream_issued", 64'(acc), 64'd100);
        wait_idle("stream");
        check("stream_returned", 64'(n_pops - p0), 64'd100);

        // Random valid/ready traffic
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            s_a = rnd_fp();
            s_b = rnd_fp();
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_idle("random");

        // Reset with 3 buffered and 5 inflight
        @(posedge clk); #1;
        m_ready = 1'b0;
        issue_n(3);
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("mid_buffered_count", 64'(count),   64'd3);
        check("mid_buffered_valid", 64'(m_valid), 64'd1);
        @(posedge clk); #1;
        issue_n(5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_total_count", 64'(count), 64'd8);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_m_valid", 64'(m_valid), 64'd0);
        check("mid_rst_count",   64'(count),   64'd0);
        @(posedge clk); #1;
        reset   = 1'b0;
        p0      = n_pops;
        s_valid = 1'b1;
        s_a     = rnd_fp();
        s_b     = rnd_fp();
        m_ready = 1'b1;
        measure_drain(1'b0, zeros, saw_mv, busy_lo);
        check("mid_drain_len",    64'(zeros),  64'd17);
        check("mid_drain_mvalid", 64'(saw_mv), 64'd0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        wait_idle("mid");
        check("mid_first_op_returned", 64'(n_pops - p0), 64'd1);

`ifdef SYNTHESIJER_FP64_CHECK_EN
        // Stray result with nothing inflight
        @(posedge clk); #1;
        inj_valid = 1'b1;
        inj_data  = rnd_fp();
        @(posedge clk); #1;
        inj_valid = 1'b0;
        @(negedge clk);
        check("chk_err_set",   64'(err),     64'd1);
        check("chk_m_valid",   64'(m_valid), 64'd0);
        check("chk_count",     64'(count),   64'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("chk_err_sticky", 64'(err), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("chk_err_cleared", 64'(err), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        measure_drain(1'b0, zeros, saw_mv, busy_lo);
        check("chk_drain_len", 64'(zeros), 64'd17);
`endif

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
